// File: rtl/ibex_irq_ctrl_if.sv
// Register access port of the interrupt aggregator: one-cycle request pulse,
// registered response one cycle later.
interface ibex_irq_ctrl_if;
  logic        req;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output rvalid, rdata
  );
endinterface

// File: rtl/ibex_irq_ctrl.sv
// Fast-interrupt aggregator: per-source edge/level gateways, claim/complete
// servicing through a small register port, and a rising-edge NMI latch.
module ibex_irq_ctrl #(
  parameter int unsigned NumSrc = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumSrc-1:0] src_i,
  input  logic              nmi_src_i,
  ibex_irq_ctrl_if.slave    reg_bus,
  output logic [NumSrc-1:0] irq_fast_o,
  output logic              irq_nm_o
);

  localparam logic [2:0] AddrPending  = 3'd0;
  localparam logic [2:0] AddrEnable   = 3'd1;
  localparam logic [2:0] AddrClaim    = 3'd2;
  localparam logic [2:0] AddrComplete = 3'd3;
  localparam logic [2:0] AddrTrigger  = 3'd4;
  localparam logic [2:0] AddrNmi      = 3'd5;

  logic [NumSrc-1:0] pending, enable, trigger, in_service, src_q;
  logic [NumSrc-1:0] pending_next, in_service_next;
  logic [NumSrc-1:0] active, claim_mask, complete_mask;
  logic              nmi_pending, nmi_q;
  logic              read_req, write_req, claim_read, claim_hit;
  logic [3:0]        claim_idx;
  logic [31:0]       read_data;
  logic              unused_wdata;

  assign read_req   = reg_bus.req & ~reg_bus.we;
  assign write_req  = reg_bus.req & reg_bus.we;
  assign claim_read = read_req & (reg_bus.addr == AddrClaim);
  assign active     = pending & enable;
  assign unused_wdata = ^reg_bus.wdata;

  // Lowest index wins, matching the core's fast-interrupt priority.
  always_comb begin
    claim_hit = 1'b0;
    claim_idx = 4'd0;
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_hit = 1'b1;
        claim_idx = 4'(i);
      end
    end
  end

  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    for (int i = 0; i < NumSrc; i++) begin
      claim_mask[i]    = claim_read & claim_hit & (claim_idx == 4'(i));
      complete_mask[i] = write_req & (reg_bus.addr == AddrComplete) &
                         (reg_bus.wdata[3:0] == 4'(i + 1));
    end
  end

  // Gateway uses in_service from before this edge, so a same-cycle COMPLETE
  // still blocks, and a same-cycle CLAIM overrides any new edge.
  always_comb begin
    pending_next = pending;
    for (int i = 0; i < NumSrc; i++) begin
      if (!in_service[i]) begin
        if (trigger[i]) begin
          pending_next[i] = pending[i] | (src_i[i] & ~src_q[i]);
        end else begin
          pending_next[i] = src_i[i];
        end
      end
      if (claim_mask[i]) begin
        pending_next[i] = 1'b0;
      end
    end
    in_service_next = (in_service & ~complete_mask) | claim_mask;
  end

  always_comb begin
    read_data = '0;
    unique case (reg_bus.addr)
      AddrPending: read_data = {{(32 - NumSrc){1'b0}}, pending};
      AddrEnable:  read_data = {{(32 - NumSrc){1'b0}}, enable};
      AddrClaim:   read_data = claim_hit ? {28'd0, claim_idx + 4'd1} : 32'd0;
      AddrTrigger: read_data = {{(32 - NumSrc){1'b0}}, trigger};
      AddrNmi:     read_data = {31'd0, nmi_pending};
      default:     read_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending        <= '0;
      enable         <= '0;
      trigger        <= '0;
      in_service     <= '0;
      src_q          <= '0;
      nmi_pending    <= 1'b0;
      nmi_q          <= 1'b0;
      reg_bus.rvalid <= 1'b0;
      reg_bus.rdata  <= '0;
    end else begin
      pending    <= pending_next;
      in_service <= in_service_next;
      src_q      <= src_i;
      nmi_q      <= nmi_src_i;
      if (write_req && reg_bus.addr == AddrEnable) begin
        enable <= reg_bus.wdata[NumSrc-1:0];
      end
      if (write_req && reg_bus.addr == AddrTrigger) begin
        trigger <= reg_bus.wdata[NumSrc-1:0];
      end
      // A new NMI edge wins over a clear landing in the same cycle.
      nmi_pending <= (nmi_src_i & ~nmi_q) |
                     (nmi_pending & ~(write_req && reg_bus.addr == AddrNmi &&
                                      reg_bus.wdata[0]));
      reg_bus.rvalid <= reg_bus.req;
      reg_bus.rdata  <= read_req ? read_data : 32'd0;
    end
  end

  assign irq_fast_o = active;
  assign irq_nm_o   = nmi_pending;

endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// Directed bench for ibex_irq_ctrl: a vector table for single-cycle behaviour
// plus hand-written claim/complete, level, conflict, NMI and reset sequences.
module tb_ibex_irq_ctrl;

  typedef struct {
    logic        req;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [14:0] src;
    logic        nmi;
    logic [31:0] exp_rdata;
    logic [14:0] exp_irq;
    logic        exp_nm;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [14:0] src;
  logic        nmi;
  logic [14:0] irq_fast;
  logic        irq_nm;
  int          compared;
  int          mismatched;
  vec_t        vecs[$];
  logic [31:0] rd;

  ibex_irq_ctrl_if bus ();

  ibex_irq_ctrl #(.NumSrc(15)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .src_i      (src),
    .nmi_src_i  (nmi),
    .reg_bus    (bus.slave),
    .irq_fast_o (irq_fast),
    .irq_nm_o   (irq_nm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One register access; the response is checked in the following cycle.
  task automatic applyStimulus(input logic we, input logic [2:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = addr;
    bus.wdata = wdata;
    tick();
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.wdata = 32'd0;
    checkOutput("rvalid", {31'd0, bus.rvalid}, 32'd1);
    rdata = bus.rdata;
  endtask

  function automatic vec_t mk(logic req, logic we, logic [2:0] addr, logic [31:0] wdata,
                              logic [14:0] s, logic n, logic [31:0] exp_rdata,
                              logic [14:0] exp_irq, logic exp_nm);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.src = s; v.nmi = n;
    v.exp_rdata = exp_rdata; v.exp_irq = exp_irq; v.exp_nm = exp_nm;
    return v;
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    src        = '0;
    nmi        = 1'b0;
    bus.req    = 1'b0;
    bus.we     = 1'b0;
    bus.addr   = 3'd0;
    bus.wdata  = 32'd0;

    // req, we, addr, wdata, src, nmi, exp_rdata, exp_irq, exp_nm
    vecs.push_back(mk(1'b1, 1'b1, 3'd1, 32'h5,    15'h0, 1'b0, 32'h0, 15'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 3'd4, 32'h4,    15'h0, 1'b0, 32'h0, 15'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,    15'h4, 1'b0, 32'h0, 15'h4, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 32'h0,    15'h0, 1'b0, 32'h4, 15'h4, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd2, 32'h0,    15'h0, 1'b0, 32'h3, 15'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd2, 32'h0,    15'h0, 1'b0, 32'h0, 15'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd1, 32'h0,    15'h0, 1'b0, 32'h5, 15'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd4, 32'h0,    15'h0, 1'b0, 32'h4, 15'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 3'd0, 32'h7fff, 15'h0, 1'b0, 32'h0, 15'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 32'h0,    15'h0, 1'b0, 32'h0, 15'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd6, 32'h0,    15'h0, 1'b0, 32'h0, 15'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 3'd7, 32'hffff, 15'h0, 1'b0, 32'h0, 15'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd3, 32'h0,    15'h0, 1'b0, 32'h0, 15'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,    15'h0, 1'b1, 32'h0, 15'h0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 32'h0,    15'h0, 1'b0, 32'h0, 15'h0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 3'd5, 32'h1,    15'h0, 1'b1, 32'h0, 15'h0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 3'd5, 32'h0,    15'h0, 1'b1, 32'h1, 15'h0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 3'd5, 32'h1,    15'h0, 1'b0, 32'h0, 15'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd5, 32'h0,    15'h0, 1'b0, 32'h0, 15'h0, 1'b0));

    tick();
    tick();
    checkOutput("reset rvalid", {31'd0, bus.rvalid}, 32'd0);
    checkOutput("reset rdata", bus.rdata, 32'd0);
    checkOutput("reset irq_fast", {17'd0, irq_fast}, 32'd0);
    checkOutput("reset irq_nm", {31'd0, irq_nm}, 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[k]) begin
      src       = vecs[k].src;
      nmi       = vecs[k].nmi;
      bus.req   = vecs[k].req;
      bus.we    = vecs[k].we;
      bus.addr  = vecs[k].addr;
      bus.wdata = vecs[k].wdata;
      tick();
      bus.req = 1'b0;
      checkOutput($sformatf("vec%0d rvalid", k), {31'd0, bus.rvalid}, {31'd0, vecs[k].req});
      if (vecs[k].req) begin
        checkOutput($sformatf("vec%0d rdata", k), bus.rdata, vecs[k].exp_rdata);
      end
      checkOutput($sformatf("vec%0d irq_fast", k), {17'd0, irq_fast}, {17'd0, vecs[k].exp_irq});
      checkOutput($sformatf("vec%0d irq_nm", k), {31'd0, irq_nm}, {31'd0, vecs[k].exp_nm});
    end
    src = '0;
    nmi = 1'b0;

    // Priority and in-service blocking; id 3 is still in service from the table.
    applyStimulus(1'b1, 3'd3, 32'd3, rd);
    applyStimulus(1'b1, 3'd4, 32'h5, rd);
    src = 15'h5; tick(); src = '0; tick();
    checkOutput("prio irq both", {17'd0, irq_fast}, 32'h5);
    applyStimulus(1'b0, 3'd2, 32'd0, rd);
    checkOutput("prio claim first", rd, 32'd1);
    checkOutput("prio irq after first", {17'd0, irq_fast}, 32'h4);
    applyStimulus(1'b0, 3'd2, 32'd0, rd);
    checkOutput("prio claim second", rd, 32'd3);
    checkOutput("prio irq after second", {17'd0, irq_fast}, 32'h0);
    src = 15'h1; tick(); src = '0; tick();
    applyStimulus(1'b0, 3'd0, 32'd0, rd);
    checkOutput("edge blocked in service", rd, 32'h0);
    applyStimulus(1'b1, 3'd3, 32'd1, rd);
    src = 15'h1; tick(); src = '0; tick();
    applyStimulus(1'b0, 3'd0, 32'd0, rd);
    checkOutput("edge after complete", rd, 32'h1);
    checkOutput("irq after complete", {17'd0, irq_fast}, 32'h1);
    applyStimulus(1'b0, 3'd2, 32'd0, rd);
    checkOutput("reclaim id1", rd, 32'd1);
    applyStimulus(1'b1, 3'd3, 32'd1, rd);
    applyStimulus(1'b1, 3'd3, 32'd3, rd);

    // Level mode on source 1.
    applyStimulus(1'b1, 3'd1, 32'h7, rd);
    src = 15'h2; tick();
    checkOutput("level irq", {17'd0, irq_fast}, 32'h2);
    applyStimulus(1'b0, 3'd2, 32'd0, rd);
    checkOutput("level claim", rd, 32'd2);
    checkOutput("level irq claimed", {17'd0, irq_fast}, 32'h0);
    tick();
    checkOutput("level irq in service", {17'd0, irq_fast}, 32'h0);
    applyStimulus(1'b1, 3'd3, 32'd2, rd);
    checkOutput("level irq complete edge", {17'd0, irq_fast}, 32'h0);
    tick();
    checkOutput("level irq reasserts", {17'd0, irq_fast}, 32'h2);
    src = '0; tick();
    checkOutput("level irq drops", {17'd0, irq_fast}, 32'h0);

    // Claim and new edge on source 3 in the same cycle.
    applyStimulus(1'b1, 3'd4, 32'hd, rd);
    applyStimulus(1'b1, 3'd1, 32'hf, rd);
    src = 15'h8; tick(); src = '0; tick();
    checkOutput("conflict irq", {17'd0, irq_fast}, 32'h8);
    src = 15'h8;
    applyStimulus(1'b0, 3'd2, 32'd0, rd);
    checkOutput("conflict claim", rd, 32'd4);
    checkOutput("conflict irq claimed", {17'd0, irq_fast}, 32'h0);
    applyStimulus(1'b0, 3'd0, 32'd0, rd);
    checkOutput("conflict pending", rd, 32'h0);
    src = '0; tick(); src = 15'h8; tick(); src = '0; tick();
    applyStimulus(1'b0, 3'd0, 32'd0, rd);
    checkOutput("conflict still in service", rd, 32'h0);
    applyStimulus(1'b1, 3'd3, 32'd4, rd);
    tick();
    tick();
    checkOutput("conflict irq after complete", {17'd0, irq_fast}, 32'h0);
    applyStimulus(1'b0, 3'd0, 32'd0, rd);
    checkOutput("conflict pending after complete", rd, 32'h0);

    // Reset mid-service.
    src = 15'h8; tick(); src = '0; tick();
    applyStimulus(1'b1, 3'd1, 32'h7fff, rd);
    applyStimulus(1'b0, 3'd2, 32'd0, rd);
    checkOutput("pre-reset claim", rd, 32'd4);
    src = 15'h1; tick(); src = '0; tick();
    nmi = 1'b1; tick(); nmi = 1'b0;
    checkOutput("pre-reset irq_fast", {17'd0, irq_fast}, 32'h1);
    checkOutput("pre-reset irq_nm", {31'd0, irq_nm}, 32'd1);
    rst_n    = 1'b0;
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 3'd1;
    tick();
    rst_n   = 1'b1;
    bus.req = 1'b0;
    checkOutput("mid reset rvalid", {31'd0, bus.rvalid}, 32'd0);
    checkOutput("mid reset rdata", bus.rdata, 32'd0);
    checkOutput("mid reset irq_fast", {17'd0, irq_fast}, 32'h0);
    checkOutput("mid reset irq_nm", {31'd0, irq_nm}, 32'd0);
    tick();
    checkOutput("dropped request rvalid", {31'd0, bus.rvalid}, 32'd0);
    applyStimulus(1'b0, 3'd1, 32'd0, rd);
    checkOutput("post-reset enable", rd, 32'h0);
    applyStimulus(1'b0, 3'd2, 32'd0, rd);
    checkOutput("post-reset claim", rd, 32'd0);
    applyStimulus(1'b0, 3'd0, 32'd0, rd);
    checkOutput("post-reset pending", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
